// File: rtl/i2s_audio_tx.sv
// I2S transmitter: one-pair holding register feeding a 2*SLOT_BITS frame shifter; BCLK/LRCK divided from AUDIO_CLK.
// A pair accepted at least one cycle before a load edge leaves MSB-first at that edge; never stalls, flags overrun/underrun instead.
module i2s_audio_tx #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_DIV      = 4
) (
  input  logic                     AUDIO_CLK,
  input  logic                     reset_data,
  input  logic                     enable,
  input  logic                     sample_valid,
  input  logic [AUD_BIT_DEPTH-1:0] lsample,
  input  logic [AUD_BIT_DEPTH-1:0] rsample,
  input  logic                     clear_flags,
  output logic                     sample_ready,
  output logic                     frame_start,
  output logic                     i2s_bclk,
  output logic                     i2s_lrck,
  output logic                     i2s_data,
  output logic                     underrun,
  output logic                     overrun
);

  localparam int FW = 2 * SLOT_BITS;
  localparam int CW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(FW);
  localparam logic [CW-1:0] C_LAST = CW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] B_LAST = BW'(FW - 1);
  localparam logic [BW-1:0] LR_LO  = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] LR_HI  = BW'(FW - 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state;
  logic [CW-1:0]            c;
  logic [BW-1:0]            b;
  logic [FW-1:0]            sh;
  logic                     full;
  logic [AUD_BIT_DEPTH-1:0] hold_l, hold_r, last_l, last_r;

  logic          active, fall, wrap, load, stop, full_nxt;
  logic [CW-1:0] c_nxt;
  logic [BW-1:0] b_nxt;
  logic [FW-1:0] frm;

  // A wrap edge with enable low ends the drain; with enable high it loads, whether in RUN or DRAIN.
  always_comb begin
    active   = (state != IDLE);
    fall     = active && (c == C_LAST);
    wrap     = fall && (b == B_LAST);
    load     = wrap && enable;
    stop     = wrap && !enable;
    c_nxt    = (!active || fall) ? '0 : c + 1'b1;
    b_nxt    = (b == B_LAST) ? '0 : b + 1'b1;
    full_nxt = sample_valid ? 1'b1 : (load ? 1'b0 : full);
    frm      = '0;
    if (full) begin
      frm[FW-1 -: AUD_BIT_DEPTH]        = hold_l;
      frm[SLOT_BITS-1 -: AUD_BIT_DEPTH] = hold_r;
    end else begin
      frm[FW-1 -: AUD_BIT_DEPTH]        = last_l;
      frm[SLOT_BITS-1 -: AUD_BIT_DEPTH] = last_r;
    end
  end

  always_ff @(posedge AUDIO_CLK) begin
    if (reset_data) begin
      state        <= IDLE;
      c            <= '0;
      b            <= B_LAST;
      sh           <= '0;
      full         <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      last_l       <= '0;
      last_r       <= '0;
      sample_ready <= 1'b1;
      frame_start  <= 1'b0;
      i2s_bclk     <= 1'b0;
      i2s_lrck     <= 1'b0;
      i2s_data     <= 1'b0;
      underrun     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (stop) state <= IDLE; else if (!enable) state <= DRAIN;
        DRAIN:   if (stop) state <= IDLE; else if (enable) state <= RUN;
        default: state <= IDLE;
      endcase

      c        <= c_nxt;
      i2s_bclk <= (c_nxt >= C_HALF);

      if (stop) begin
        b        <= B_LAST;
        i2s_lrck <= 1'b0;
        i2s_data <= 1'b0;
      end else if (fall) begin
        b        <= b_nxt;
        i2s_lrck <= (b_nxt >= LR_LO) && (b_nxt <= LR_HI);
        if (load) begin
          i2s_data <= frm[FW-1];
          sh       <= frm << 1;
        end else begin
          i2s_data <= sh[FW-1];
          sh       <= sh << 1;
        end
      end

      // A strobe coinciding with a load refills the register the shifter just emptied.
      if (sample_valid) begin
        hold_l <= lsample;
        hold_r <= rsample;
      end
      if (load && full) begin
        last_l <= hold_l;
        last_r <= hold_r;
      end
      full         <= full_nxt;
      sample_ready <= ~full_nxt;
      frame_start  <= load;

      underrun <= (load && !full) || (underrun && !clear_flags);
      overrun  <= (sample_valid && full && !load) || (overrun && !clear_flags);
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: frame capture at negedges against hand-built expected frames.
module tb_i2s_audio_tx;

  logic        AUDIO_CLK = 1'b0;
  logic        reset_data, enable, sample_valid, clear_flags;
  logic [23:0] lsample, rsample;
  logic        sample_ready, frame_start, i2s_bclk, i2s_lrck, i2s_data, underrun, overrun;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] cap_data, cap_lrck;
  int          cap_bclk_err, cap_fs_cnt;

  localparam logic [63:0] LRCK_EXP = 64'h00000001_FFFFFFFE;

  i2s_audio_tx dut (
    .AUDIO_CLK    (AUDIO_CLK),
    .reset_data   (reset_data),
    .enable       (enable),
    .sample_valid (sample_valid),
    .lsample      (lsample),
    .rsample      (rsample),
    .clear_flags  (clear_flags),
    .sample_ready (sample_ready),
    .frame_start  (frame_start),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_data     (i2s_data),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  always #5 AUDIO_CLK = ~AUDIO_CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<500000", $time);
    $fatal(1);
  end

  task automatic wait_fs(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge AUDIO_CLK);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Starts on the negedge where frame_start is high; ends on the first negedge of the next frame.
  task automatic capture_frame();
    cap_data = '0;
    cap_lrck = '0;
    cap_bclk_err = 0;
    cap_fs_cnt = 0;
    for (int bi = 0; bi < 64; bi++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 0) begin
          cap_data[63-bi] = i2s_data;
          cap_lrck[63-bi] = i2s_lrck;
        end
        if (i2s_bclk !== (k >= 2)) cap_bclk_err++;
        if (frame_start === 1'b1) cap_fs_cnt++;
        @(negedge AUDIO_CLK);
      end
    end
  endtask

  task automatic test_reset();
    reset_data = 1'b1; enable = 1'b0; sample_valid = 1'b0; clear_flags = 1'b0;
    lsample = '0; rsample = '0;
    repeat (2) @(posedge AUDIO_CLK);
    @(negedge AUDIO_CLK);
    vectors++;
    if ({sample_ready, frame_start, i2s_bclk, i2s_lrck, i2s_data, underrun, overrun} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 1000000",
               {sample_ready, frame_start, i2s_bclk, i2s_lrck, i2s_data, underrun, overrun});
    end
    reset_data = 1'b0;
  endtask

  task automatic test_first_frame();
    bit ok;
    enable = 1'b1; sample_valid = 1'b1; lsample = 24'hABCDEF; rsample = 24'h123456;
    @(posedge AUDIO_CLK); #1 sample_valid = 1'b0;
    @(negedge AUDIO_CLK);
    vectors++;
    if (sample_ready !== 1'b0) begin miscompares++; $display("FAIL t1_ready_full: got %b required 0", sample_ready); end
    wait_fs(20, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL t1_fs_seen: got 0 required 1"); end
    vectors++;
    if (sample_ready !== 1'b1) begin miscompares++; $display("FAIL t1_ready_empty: got %b required 1", sample_ready); end
    capture_frame();
    vectors++;
    if (cap_data !== 64'hABCDEF00_12345600) begin miscompares++; $display("FAIL t1_data: got %h required abcdef0012345600", cap_data); end
    vectors++;
    if (cap_lrck !== LRCK_EXP) begin miscompares++; $display("FAIL t1_lrck: got %h required %h", cap_lrck, LRCK_EXP); end
    vectors++;
    if (cap_bclk_err != 0) begin miscompares++; $display("FAIL t1_bclk: got %0d bad samples required 0", cap_bclk_err); end
    vectors++;
    if (cap_fs_cnt != 1) begin miscompares++; $display("FAIL t1_fs_once: got %0d required 1", cap_fs_cnt); end
    vectors++;
    if (frame_start !== 1'b1) begin miscompares++; $display("FAIL t1_period256: got fs=%b required 1", frame_start); end
  endtask

  task automatic test_underrun();
    capture_frame();
    vectors++;
    if (cap_data !== 64'hABCDEF00_12345600) begin miscompares++; $display("FAIL t2_repeat: got %h required abcdef0012345600", cap_data); end
    vectors++;
    if (underrun !== 1'b1) begin miscompares++; $display("FAIL t2_underrun_set: got %b required 1", underrun); end
    @(posedge AUDIO_CLK); #1 clear_flags = 1'b1;
    @(posedge AUDIO_CLK); #1 clear_flags = 1'b0;
    @(negedge AUDIO_CLK);
    vectors++;
    if (underrun !== 1'b0) begin miscompares++; $display("FAIL t2_underrun_clr: got %b required 0", underrun); end
  endtask

  task automatic test_overrun();
    bit ok;
    sample_valid = 1'b1; lsample = 24'h000001; rsample = 24'h000001;
    @(posedge AUDIO_CLK); #1 sample_valid = 1'b0;
    @(negedge AUDIO_CLK);
    vectors++;
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL t3_no_overrun_yet: got %b required 0", overrun); end
    sample_valid = 1'b1; lsample = 24'h7FFFFF; rsample = 24'h7FFFFF;
    @(posedge AUDIO_CLK); #1 sample_valid = 1'b0;
    @(negedge AUDIO_CLK);
    vectors++;
    if (overrun !== 1'b1) begin miscompares++; $display("FAIL t3_overrun: got %b required 1", overrun); end
    wait_fs(300, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL t3_fs_seen: got 0 required 1"); end
    capture_frame();
    vectors++;
    if (cap_data !== 64'h7FFFFF00_7FFFFF00) begin miscompares++; $display("FAIL t3_data: got %h required 7fffff007fffff00", cap_data); end
  endtask

  task automatic test_back_to_back();
    // Entered on the frame_start negedge; the next load edge ends interval F+255.
    @(posedge AUDIO_CLK);
    #1 clear_flags = 1'b1; sample_valid = 1'b1; lsample = 24'h5A5A5A; rsample = 24'h0F0F0F;
    @(posedge AUDIO_CLK);
    #1 clear_flags = 1'b0; sample_valid = 1'b0;
    repeat (253) @(posedge AUDIO_CLK);
    #1 sample_valid = 1'b1; lsample = 24'hC3C3C3; rsample = 24'h3C3C3C;
    @(posedge AUDIO_CLK);
    #1 sample_valid = 1'b0;
    @(negedge AUDIO_CLK);
    vectors++;
    if (frame_start !== 1'b1) begin miscompares++; $display("FAIL t4_load_edge: got fs=%b required 1", frame_start); end
    vectors++;
    if (sample_ready !== 1'b0) begin miscompares++; $display("FAIL t4_ready: got %b required 0", sample_ready); end
    vectors++;
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL t4_overrun: got %b required 0", overrun); end
    capture_frame();
    vectors++;
    if (cap_data !== 64'h5A5A5A00_0F0F0F00) begin miscompares++; $display("FAIL t4_old_pair: got %h required 5a5a5a000f0f0f00", cap_data); end
    capture_frame();
    vectors++;
    if (cap_data !== 64'hC3C3C300_3C3C3C00) begin miscompares++; $display("FAIL t4_new_pair: got %h required c3c3c3003c3c3c00", cap_data); end
    vectors++;
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL t4_overrun_end: got %b required 0", overrun); end
  endtask

  task automatic test_drain();
    int fs_cnt, bclk_hi;
    repeat (40) @(posedge AUDIO_CLK);
    #1 enable = 1'b0;
    repeat (208) @(posedge AUDIO_CLK);
    @(negedge AUDIO_CLK);
    vectors++;
    if ({i2s_lrck, i2s_data} !== 2'b10) begin miscompares++; $display("FAIL t5_b62: got lrck,data=%b required 10", {i2s_lrck, i2s_data}); end
    repeat (6) @(posedge AUDIO_CLK);
    @(negedge AUDIO_CLK);
    vectors++;
    if ({i2s_bclk, i2s_lrck} !== 2'b10) begin miscompares++; $display("FAIL t5_b63: got bclk,lrck=%b required 10", {i2s_bclk, i2s_lrck}); end
    repeat (2) @(posedge AUDIO_CLK);
    @(negedge AUDIO_CLK);
    vectors++;
    if ({frame_start, i2s_bclk, i2s_lrck, i2s_data} !== 4'b0000) begin
      miscompares++;
      $display("FAIL t5_idle: got fs,bclk,lrck,data=%b required 0000", {frame_start, i2s_bclk, i2s_lrck, i2s_data});
    end
    fs_cnt = 0; bclk_hi = 0;
    repeat (300) begin
      @(negedge AUDIO_CLK);
      if (frame_start === 1'b1) fs_cnt++;
      if (i2s_bclk !== 1'b0) bclk_hi++;
    end
    vectors++;
    if (fs_cnt != 0 || bclk_hi != 0) begin miscompares++; $display("FAIL t5_quiet: got fs=%0d bclk_hi=%0d required 0 0", fs_cnt, bclk_hi); end
    @(posedge AUDIO_CLK);
    #1 enable = 1'b1;
    repeat (4) @(posedge AUDIO_CLK);
    @(negedge AUDIO_CLK);
    vectors++;
    if (frame_start !== 1'b0) begin miscompares++; $display("FAIL t5_early: got fs=%b required 0", frame_start); end
    @(posedge AUDIO_CLK);
    @(negedge AUDIO_CLK);
    vectors++;
    if ({frame_start, i2s_data} !== 2'b11) begin miscompares++; $display("FAIL t5_restart_msb: got fs,data=%b required 11", {frame_start, i2s_data}); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    repeat (160) @(posedge AUDIO_CLK);
    #1 reset_data = 1'b1;
    @(posedge AUDIO_CLK);
    @(negedge AUDIO_CLK);
    vectors++;
    if ({sample_ready, frame_start, i2s_bclk, i2s_lrck, i2s_data, underrun, overrun} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL t6_reset_outputs: got %b required 1000000",
               {sample_ready, frame_start, i2s_bclk, i2s_lrck, i2s_data, underrun, overrun});
    end
    reset_data = 1'b0;
    wait_fs(20, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL t6_fs_seen: got 0 required 1"); end
    capture_frame();
    vectors++;
    if (cap_data !== 64'h0) begin miscompares++; $display("FAIL t6_zeros: got %h required 0", cap_data); end
    vectors++;
    if (underrun !== 1'b1) begin miscompares++; $display("FAIL t6_underrun: got %b required 1", underrun); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_underrun();
    test_overrun();
    test_back_to_back();
    test_drain();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
